// File: rtl/alu_mdu_pkg.sv
// Opcode map and divider state type shared by the execute-stage ALU/MDU.
package alu_mdu_pkg;

  localparam logic [7:0] EXE_AND_OP   = 8'h24;
  localparam logic [7:0] EXE_OR_OP    = 8'h25;
  localparam logic [7:0] EXE_XOR_OP   = 8'h26;
  localparam logic [7:0] EXE_NOR_OP   = 8'h27;
  localparam logic [7:0] EXE_ANDI_OP  = 8'h59;
  localparam logic [7:0] EXE_ORI_OP   = 8'h5A;
  localparam logic [7:0] EXE_XORI_OP  = 8'h5B;
  localparam logic [7:0] EXE_LUI_OP   = 8'h5C;
  localparam logic [7:0] EXE_SLL_OP   = 8'h7C;
  localparam logic [7:0] EXE_SLLV_OP  = 8'h04;
  localparam logic [7:0] EXE_SRL_OP   = 8'h02;
  localparam logic [7:0] EXE_SRLV_OP  = 8'h06;
  localparam logic [7:0] EXE_SRA_OP   = 8'h03;
  localparam logic [7:0] EXE_SRAV_OP  = 8'h07;
  localparam logic [7:0] EXE_MFHI_OP  = 8'h10;
  localparam logic [7:0] EXE_MTHI_OP  = 8'h11;
  localparam logic [7:0] EXE_MFLO_OP  = 8'h12;
  localparam logic [7:0] EXE_MTLO_OP  = 8'h13;
  localparam logic [7:0] EXE_SLT_OP   = 8'h2A;
  localparam logic [7:0] EXE_SLTU_OP  = 8'h2B;
  localparam logic [7:0] EXE_ADD_OP   = 8'h20;
  localparam logic [7:0] EXE_ADDU_OP  = 8'h21;
  localparam logic [7:0] EXE_SUB_OP   = 8'h22;
  localparam logic [7:0] EXE_SUBU_OP  = 8'h23;
  localparam logic [7:0] EXE_ADDI_OP  = 8'h55;
  localparam logic [7:0] EXE_MULT_OP  = 8'h18;
  localparam logic [7:0] EXE_MULTU_OP = 8'h19;
  localparam logic [7:0] EXE_DIV_OP   = 8'h1A;
  localparam logic [7:0] EXE_DIVU_OP  = 8'h1B;
  localparam logic [7:0] EXE_LW_OP    = 8'hE3;
  localparam logic [7:0] EXE_SW_OP    = 8'hEB;
  localparam logic [7:0] EXE_BEQ_OP   = 8'h51;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/alu_mdu_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per step.
// Only built when ALU_MDU_DIV_EN is defined.
`ifdef ALU_MDU_DIV_EN
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done_c
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   trial_c;
  logic [WIDTH:0]   diff_c;

  // Partial remainder shifted left with the next dividend bit, then trial-subtracted.
  assign trial_c = {remainder, quotient[WIDTH-1]};
  assign diff_c  = trial_c - {1'b0, dvs};
  assign done_c  = step && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dvs       <= '0;
    end else if (start) begin
      cnt       <= '0;
      quotient  <= dividend;
      remainder <= '0;
      dvs       <= divisor;
    end else if (step) begin
      cnt <= cnt + CW'(1);
      if (diff_c[WIDTH]) begin
        remainder <= trial_c[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end else begin
        remainder <= diff_c[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule
`endif

// File: rtl/alu_mdu.sv
// Execute-stage ALU with MULT/MTHI/MTLO and architectural HI/LO registers.
// Define ALU_MDU_DIV_EN to build the iterative DIV/DIVU unit; otherwise DIV/DIVU decode as unknown ops.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   offset,
  input  logic [7:0]       op,
  input  logic             valid,
  input  logic             flush,
  output logic [WIDTH-1:0] y,
  output logic             overflow,
  output logic             zero,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned LUI_SH = (WIDTH > 16) ? WIDTH - 16 : 0;

  logic [WIDTH-1:0]   sum_c;
  logic [WIDTH-1:0]   diff_c;
  logic [2*WIDTH-1:0] prod_s_c;
  logic [2*WIDTH-1:0] prod_u_c;
  logic               wr_en_c;
  logic               div_wr_c;
  logic [WIDTH-1:0]   div_hi_c;
  logic [WIDTH-1:0]   div_lo_c;

  assign sum_c    = a + b;
  assign diff_c   = a - b;
  assign prod_s_c = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u_c = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign wr_en_c  = valid && !flush;

  // Single-cycle result mux and signed-overflow detect.
  always_comb begin
    y        = '0;
    overflow = 1'b0;
    case (op)
      EXE_ADD_OP, EXE_ADDI_OP: begin
        y        = sum_c;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      EXE_SUB_OP: begin
        y        = diff_c;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
      end
      EXE_ADDU_OP, EXE_LW_OP, EXE_SW_OP: y = sum_c;
      EXE_SUBU_OP, EXE_BEQ_OP:           y = diff_c;
      EXE_AND_OP, EXE_ANDI_OP:           y = a & b;
      EXE_OR_OP, EXE_ORI_OP:             y = a | b;
      EXE_XOR_OP, EXE_XORI_OP:           y = a ^ b;
      EXE_NOR_OP:                        y = ~(a | b);
      EXE_SLT_OP:                        y = WIDTH'($signed(a) < $signed(b));
      EXE_SLTU_OP:                       y = WIDTH'(a < b);
      EXE_LUI_OP:                        y = b << LUI_SH;
      EXE_SLL_OP:                        y = b << offset;
      EXE_SRL_OP:                        y = b >> offset;
      EXE_SRA_OP:                        y = $unsigned($signed(b) >>> offset);
      EXE_SLLV_OP:                       y = b << a[SHW-1:0];
      EXE_SRLV_OP:                       y = b >> a[SHW-1:0];
      EXE_SRAV_OP:                       y = $unsigned($signed(b) >>> a[SHW-1:0]);
      EXE_MFHI_OP:                       y = hi;
      EXE_MFLO_OP:                       y = lo;
      default:                           y = '0;
    endcase
  end

  assign zero = (y == '0);

  // Divide completion takes priority; it only ever coincides with the held DIV op.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (div_wr_c) begin
      hi <= div_hi_c;
      lo <= div_lo_c;
    end else if (wr_en_c) begin
      case (op)
        EXE_MULT_OP:  {hi, lo} <= prod_s_c;
        EXE_MULTU_OP: {hi, lo} <= prod_u_c;
        EXE_MTHI_OP:  hi <= a;
        EXE_MTLO_OP:  lo <= a;
        default: ;
      endcase
    end
  end

`ifdef ALU_MDU_DIV_EN
  div_state_e       state;
  div_state_e       state_nx;
  logic             issue_c;
  logic             sgn_c;
  logic             start_c;
  logic             step_c;
  logic             done_c;
  logic             a_neg;
  logic             q_neg;
  logic             b_zero;
  logic [WIDTH-1:0] a_hold;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  assign issue_c = wr_en_c && ((op == EXE_DIV_OP) || (op == EXE_DIVU_OP));
  assign sgn_c   = (op == EXE_DIV_OP);
  assign a_mag_c = (sgn_c && a[WIDTH-1]) ? -a : a;
  assign b_mag_c = (sgn_c && b[WIDTH-1]) ? -b : b;

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start_c),
    .step      (step_c),
    .dividend  (a_mag_c),
    .divisor   (b_mag_c),
    .quotient  (quo),
    .remainder (rem),
    .done_c    (done_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nx;
  end

  // Signs and raw dividend held for the fix-up once the magnitudes are done.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_neg  <= 1'b0;
      q_neg  <= 1'b0;
      b_zero <= 1'b0;
      a_hold <= '0;
    end else if (start_c) begin
      a_neg  <= sgn_c && a[WIDTH-1];
      q_neg  <= sgn_c && (a[WIDTH-1] ^ b[WIDTH-1]);
      b_zero <= (b == '0);
      a_hold <= a;
    end
  end

  always_comb begin
    state_nx = state;
    start_c  = 1'b0;
    step_c   = 1'b0;
    div_wr_c = 1'b0;
    stall    = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (issue_c) begin
          start_c  = 1'b1;
          stall    = 1'b1;
          state_nx = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        step_c = 1'b1;
        stall  = 1'b1;
        if (done_c) state_nx = DIV_DONE;
      end
      DIV_DONE: begin
        div_wr_c = 1'b1;
        state_nx = DIV_IDLE;
      end
      default: state_nx = DIV_IDLE;
    endcase
    if (flush) begin
      state_nx = DIV_IDLE;
      step_c   = 1'b0;
      div_wr_c = 1'b0;
      stall    = 1'b0;
    end
    if (rst) stall = 1'b0;
  end

  // Divide-by-zero returns all-ones/dividend; MIN/-1 falls out of the magnitude path.
  always_comb begin
    if (b_zero) begin
      div_lo_c = '1;
      div_hi_c = a_hold;
    end else begin
      div_lo_c = q_neg ? -quo : quo;
      div_hi_c = a_neg ? -rem : rem;
    end
  end
`else
  assign stall    = 1'b0;
  assign div_wr_c = 1'b0;
  assign div_hi_c = '0;
  assign div_lo_c = '0;
`endif

endmodule

// File: tb/tb_alu_mdu.sv
// Randomised and directed check of alu_mdu against a behavioural integer model.
module tb_alu_mdu;
  import alu_mdu_pkg::*;

  localparam int unsigned W    = 32;
  localparam longint      SMAX = 64'sd2147483647;
  localparam longint      SMIN = -SMAX - 64'sd1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, y, hi, lo;
  logic [4:0]  offset;
  logic [7:0]  op;
  logic        valid, flush, overflow, zero, stall;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [7:0]  ops[$];

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .offset(offset), .op(op),
    .valid(valid), .flush(flush), .y(y), .overflow(overflow), .zero(zero),
    .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] o, input logic [31:0] ra, input logic [31:0] rb,
                       input logic [4:0] sh);
    op = o; a = ra; b = rb; offset = sh; valid = 1'b1; flush = 1'b0;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h7FFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'hFFFFFFFF;
      4:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Reference result from the opcode's arithmetic meaning on 64-bit integers.
  function automatic void ref_comb(input logic [7:0] o, input logic [31:0] ra, input logic [31:0] rb,
                                   input logic [4:0] sh, output logic [31:0] ry, output logic rov);
    longint sa, sb, r;
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    r  = 0;
    ry = '0;
    rov = 1'b0;
    case (o)
      EXE_ADD_OP, EXE_ADDI_OP: begin r = sa + sb; ry = r[31:0]; rov = (r > SMAX) || (r < SMIN); end
      EXE_SUB_OP:              begin r = sa - sb; ry = r[31:0]; rov = (r > SMAX) || (r < SMIN); end
      EXE_ADDU_OP, EXE_LW_OP, EXE_SW_OP: begin r = sa + sb; ry = r[31:0]; end
      EXE_SUBU_OP, EXE_BEQ_OP:           begin r = sa - sb; ry = r[31:0]; end
      EXE_AND_OP, EXE_ANDI_OP: ry = ra & rb;
      EXE_OR_OP, EXE_ORI_OP:   ry = ra | rb;
      EXE_XOR_OP, EXE_XORI_OP: ry = ra ^ rb;
      EXE_NOR_OP:              ry = ~(ra | rb);
      EXE_SLT_OP:              ry = (sa < sb) ? 32'd1 : 32'd0;
      EXE_SLTU_OP:             ry = (ra < rb) ? 32'd1 : 32'd0;
      EXE_LUI_OP:              ry = {rb[15:0], 16'h0000};
      EXE_SLL_OP:              ry = rb << sh;
      EXE_SRL_OP:              ry = rb >> sh;
      EXE_SRA_OP:              begin r = sb >>> sh; ry = r[31:0]; end
      EXE_SLLV_OP:             ry = rb << ra[4:0];
      EXE_SRLV_OP:             ry = rb >> ra[4:0];
      EXE_SRAV_OP:             begin r = sb >>> ra[4:0]; ry = r[31:0]; end
      EXE_MFHI_OP:             ry = m_hi;
      EXE_MFLO_OP:             ry = m_lo;
      default:                 ry = '0;
    endcase
  endfunction

  function automatic void ref_div(input logic sgn, input logic [31:0] ra, input logic [31:0] rb,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, qq, rr;
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    if (rb == 32'h0) begin
      q = '1; r = ra;
    end else if (sgn && ra == 32'h80000000 && rb == 32'hFFFFFFFF) begin
      q = 32'h80000000; r = '0;
    end else if (sgn) begin
      qq = sa / sb; rr = sa % sb;
      q = qq[31:0]; r = rr[31:0];
    end else begin
      q = ra / rb; r = ra % rb;
    end
  endfunction

  // Architectural HI/LO effect of the op currently presented, applied at the coming edge.
  task automatic model_commit();
    longint          p;
    longint unsigned pu;
    if (rst) begin
      m_hi = '0; m_lo = '0;
    end else if (valid && !flush) begin
      case (op)
        EXE_MULT_OP:  begin p = longint'($signed(a)) * longint'($signed(b)); m_hi = p[63:32]; m_lo = p[31:0]; end
        EXE_MULTU_OP: begin pu = {32'h0, a} * {32'h0, b}; m_hi = pu[63:32]; m_lo = pu[31:0]; end
        EXE_MTHI_OP:  m_hi = a;
        EXE_MTLO_OP:  m_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic check_comb(input string tag);
    logic [31:0] ey;
    logic        eov;
    ref_comb(op, a, b, offset, ey, eov);
    check({tag, "_y"}, 64'(y), 64'(ey));
    check({tag, "_ovf"}, 64'(overflow), 64'(eov));
    check({tag, "_zero"}, 64'(zero), 64'(ey == 32'h0));
    check({tag, "_stall"}, 64'(stall), 64'(0));
  endtask

`ifdef ALU_MDU_DIV_EN
  task automatic run_div(input logic [7:0] o, input logic [31:0] ra, input logic [31:0] rb,
                         input string tag);
    logic [31:0] eq, er;
    int          cnt;
    ref_div(o == EXE_DIV_OP, ra, rb, eq, er);
    drive(o, ra, rb, 5'd0);
    cnt = 0;
    #3;
    while (stall && cnt < 100) begin
      cnt++;
      tick();
      #3;
    end
    check({tag, "_stall_cycles"}, 64'(cnt), 64'(W + 1));
    check({tag, "_done_hold"}, {hi, lo}, {m_hi, m_lo});
    tick();
    drive(EXE_MFLO_OP, 32'h0, 32'h0, 5'd0);
    #3;
    check({tag, "_no_restart"}, 64'(stall), 64'(0));
    check({tag, "_lo"}, 64'(lo), 64'(eq));
    check({tag, "_hi"}, 64'(hi), 64'(er));
    check({tag, "_mflo"}, 64'(y), 64'(eq));
    m_hi = er;
    m_lo = eq;
    tick();
  endtask
`endif

  initial begin
    ops = '{EXE_ADD_OP, EXE_ADDI_OP, EXE_ADDU_OP, EXE_SUB_OP, EXE_SUBU_OP, EXE_AND_OP,
            EXE_ANDI_OP, EXE_OR_OP, EXE_ORI_OP, EXE_XOR_OP, EXE_XORI_OP, EXE_NOR_OP,
            EXE_SLT_OP, EXE_SLTU_OP, EXE_LUI_OP, EXE_LW_OP, EXE_SW_OP, EXE_BEQ_OP,
            EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP, EXE_SLLV_OP, EXE_SRLV_OP, EXE_SRAV_OP,
            EXE_MFHI_OP, EXE_MFLO_OP, EXE_MTHI_OP, EXE_MTLO_OP, EXE_MULT_OP,
            EXE_MULTU_OP, 8'hFF};
`ifndef ALU_MDU_DIV_EN
    ops.push_back(EXE_DIV_OP);
    ops.push_back(EXE_DIVU_OP);
`endif

    // Reset: a DIV presented under reset must not stall.
    rst = 1'b1;
    drive(EXE_DIV_OP, 32'd10, 32'd3, 5'd0);
    #3;
    check("rst_stall", 64'(stall), 64'(0));
    tick();
    tick();
    check("rst_hilo", {hi, lo}, 64'h0);
    rst = 1'b0;

    // Directed combinational corners.
    drive(EXE_ADD_OP, 32'h7FFFFFFF, 32'h1, 5'd0);
    #3;
    check("add_ovf_y", 64'(y), 64'h80000000);
    check("add_ovf_flag", 64'(overflow), 64'(1));
    tick();
    drive(EXE_SRAV_OP, 32'h24, 32'h80000000, 5'd0);
    #3;
    check("srav_y", 64'(y), 64'hF8000000);
    tick();
    drive(EXE_SUB_OP, 32'h1234, 32'h1234, 5'd0);
    #3;
    check("sub_zero", 64'(zero), 64'(1));
    tick();

    // MULT / MULTU with -3 and 5.
    drive(EXE_MULT_OP, 32'hFFFFFFFD, 32'd5, 5'd0);
    tick();
    check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    drive(EXE_MULTU_OP, 32'hFFFFFFFD, 32'd5, 5'd0);
    tick();
    check("multu_hilo", {hi, lo}, 64'h00000004_FFFFFFF1);
    m_hi = 32'h4;
    m_lo = 32'hFFFFFFF1;
    drive(EXE_MFHI_OP, 32'h0, 32'h0, 5'd0);
    #3;
    check("mfhi_after_multu", 64'(y), 64'h4);
    tick();

    // Randomised single-cycle and HI/LO-writing ops.
    for (int i = 0; i < 300; i++) begin
      drive(ops[$urandom_range(0, ops.size() - 1)], rand_val(), rand_val(), 5'($urandom));
      valid = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 9) == 0);
      #3;
      check_comb("rand");
      model_commit();
      tick();
      check("rand_hilo", {hi, lo}, {m_hi, m_lo});
    end

    // A divide presented together with flush must not start.
    drive(EXE_DIV_OP, 32'd50, 32'd5, 5'd0);
    flush = 1'b1;
    #3;
    check("flush_issue_stall", 64'(stall), 64'(0));
    tick();
    drive(EXE_MFHI_OP, 32'h0, 32'h0, 5'd0);
    #3;
    check("flush_issue_idle", 64'(stall), 64'(0));
    check("flush_issue_hilo", {hi, lo}, {m_hi, m_lo});
    tick();

`ifdef ALU_MDU_DIV_EN
    run_div(EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, "div_m7_2");
    run_div(EXE_DIVU_OP, 32'd9, 32'd0, "divu_by0");
    run_div(EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, "div_min_m1");
    for (int i = 0; i < 6; i++)
      run_div(($urandom_range(0, 1) != 0) ? EXE_DIV_OP : EXE_DIVU_OP, rand_val(),
              ($urandom_range(0, 3) == 0) ? 32'h0 : rand_val(), "div_rand");

    // Flush at BUSY cycle 10 abandons the divide without touching HI/LO.
    drive(EXE_DIV_OP, 32'd100, 32'd7, 5'd0);
    #3;
    check("abort_issue_stall", 64'(stall), 64'(1));
    for (int k = 0; k < 10; k++) tick();
    flush = 1'b1;
    #3;
    check("abort_flush_stall", 64'(stall), 64'(0));
    tick();
    drive(EXE_MFHI_OP, 32'h0, 32'h0, 5'd0);
    #3;
    check("abort_idle_stall", 64'(stall), 64'(0));
    check("abort_hilo", {hi, lo}, {m_hi, m_lo});
    tick();
`else
    // Without the divider DIV is an unknown op.
    drive(EXE_DIV_OP, 32'd90, 32'd7, 5'd0);
    #3;
    check("nodiv_y", 64'(y), 64'(0));
    check("nodiv_stall", 64'(stall), 64'(0));
    tick();
    check("nodiv_hilo", {hi, lo}, {m_hi, m_lo});
`endif

    // Reset during an in-flight divide clears HI/LO.
    drive(EXE_MTHI_OP, 32'h1234, 32'h0, 5'd0);
    model_commit();
    tick();
    drive(EXE_MTLO_OP, 32'h5678, 32'h0, 5'd0);
    model_commit();
    tick();
    check("mt_hilo", {hi, lo}, {m_hi, m_lo});
    drive(EXE_DIV_OP, 32'd1000, 32'd3, 5'd0);
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    #3;
    check("rst_mid_stall", 64'(stall), 64'(0));
    tick();
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    drive(EXE_MFHI_OP, 32'h0, 32'h0, 5'd0);
    #3;
    check("rst_mid_hilo", {hi, lo}, 64'h0);
    check("rst_mid_idle", 64'(stall), 64'(0));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execute-stage ALU with an integrated multiply/divide unit and architectural HI/LO registers. Performs all single-cycle integer ops combinationally, single-cycle MULT/MULTU, and multi-cycle iterative DIV/DIVU, asserting `stall` to freeze the pipeline while a divide is in flight. Sits in the EX stage of the MIPS datapath and replaces the plain combinational ALU there.

## Interface
- `WIDTH`, 32, datapath width; must be at least 8.
- `SHW`, `$clog2(WIDTH)`, shift-amount width; derived, not overridden.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a`, `b`  in  WIDTH  operands.
- `offset`  in  SHW  shamt for SLL/SRL/SRA.
- `op`  in  8  `EXE_*_OP` code.
- `valid`  in  1  op in EX is a real instruction, not a bubble.
- `flush`  in  1  exception/flush; kills in-flight divide.
- `y`  out  WIDTH  result (combinational).
- `overflow`  out  1  signed overflow for ADD/ADDI/SUB.
- `zero`  out  1  `y == 0`.
- `stall`  out  1  hold the pipeline; divide in progress.
- `hi`, `lo`  out  WIDTH  current HI/LO register contents.

## Operation
- Combinational ops: ADD, ADDI, ADDU, SUB, SUBU, AND, ANDI, OR, ORI, XOR, XORI, NOR, SLT (signed), SLTU, LUI (`{b[15:0],0}`), LW/SW (`a+b`), BEQ (`a-b`).
- Shifts: SLL, SRL, SRA by `offset`. SLLV, SRLV, SRAV by `a[SHW-1:0]` only. Upper bits of `a` are ignored.
- MFHI/MFLO: `y = hi/lo`. Any unknown op: `y = 0`.
- Writes to HI/LO happen only when `valid && !flush`:
  - MULT/MULTU: `{hi,lo}` = 2·WIDTH-bit signed/unsigned product, written at the end of the issue cycle.
  - MTHI: `hi <= a`. MTLO: `lo <= a`.
- DIV/DIVU algorithm:
  - Radix-2 restoring division on magnitudes, one quotient bit per cycle.
  - Signed fix-up: quotient sign = `a^b`; remainder sign = sign of `a`.
  - `lo` = quotient, `hi` = remainder.
  - Divide by zero: `lo` = all-ones, `hi` = `a`.
  - Signed MIN / −1: `lo` = MIN, `hi` = 0.
- Divider FSM:
  - IDLE → BUSY when `valid && !flush` and op is DIV/DIVU. Latch magnitudes and signs; clear step counter.
  - BUSY: one step per cycle; counter increments. After step WIDTH → DONE.
  - DONE: write HI/LO; → IDLE unconditionally. The still-present DIV op in DONE does not re-trigger.
  - `flush` in any state → IDLE next edge. HI/LO unchanged.
- `stall` = (IDLE && `valid` && DIV op && `!flush`) || BUSY. It is low in DONE and low in any flush cycle.
- `overflow`:
  - ADD/ADDI: operands share a sign and `y` differs from it.
  - SUB: operand signs differ and `y` sign ≠ `a` sign.
  - All other ops: 0.

## Timing
- Reset values: state IDLE, counter 0, `hi = lo = 0`, `stall = 0` (forced while `rst`).
- `y`, `zero`, `overflow`: same-cycle combinational, no reset value.
- MULT/MTHI/MTLO: HI/LO visible to MFHI/MFLO in the next cycle. No stall.
- DIV issued in cycle 0:
  - `stall` high in cycles 0..WIDTH (WIDTH+1 cycles).
  - Cycle WIDTH+1 is DONE: `stall` low; HI/LO written at the end of that cycle.
  - MFHI in cycle WIDTH+2 sees the result.
- `rst` mid-divide: IDLE next edge, HI/LO cleared.
- Simultaneous `flush` and DIV issue: the divide is not started and `stall` stays low.

## Configuration
- `ALU_MDU_DIV_EN` defined: divider FSM and sub-module are built as above.
- `ALU_MDU_DIV_EN` not defined:
  - DIV/DIVU behave as unknown ops: `y = 0`, no stall, HI/LO unchanged.
  - The FSM is absent and `stall` is tied to 0.

## Structure
- `defines.vh` adds these `EXE_*_OP` codes: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, ADDU, SUBU, SLTU.
- `defines.vh` also holds the divider state encodings (IDLE/BUSY/DONE).
- Sub-module `div_iter`: magnitude restoring divider with start/step/done, parametrised by WIDTH. `alu_mdu` owns the sign fix-up and HI/LO.

## Test plan
- Combinational ops (WIDTH=32):
  - ADD `0x7FFFFFFF+1` → `y = 0x80000000`, `overflow = 1`.
  - SRAV `b = 0x80000000`, `a = 0x24` → shift by 4, `y = 0xF8000000`.
- MULT `a = -3`, `b = 5` → next cycle `hi = 0xFFFFFFFF`, `lo = 0xFFFFFFF1`. MULTU with the same operands → `hi = 4`, `lo = 0xFFFFFFF1`.
- DIV `a = -7`, `b = 2`:
  - `stall` high exactly 33 cycles.
  - Then `lo = 0xFFFFFFFD`, `hi = 0xFFFFFFFF`.
  - The held op does not restart the divide.
- DIVU `a = 9`, `b = 0` → `lo = 0xFFFFFFFF`, `hi = 9`. DIV `0x80000000 / -1` → `lo = 0x80000000`, `hi = 0`.
- Abort cases:
  - `flush` at BUSY cycle 10 → `stall` low in that cycle, IDLE next, HI/LO unchanged.
  - `rst` mid-divide → `hi = lo = 0`.
- WIDTH=16 with `ALU_MDU_DIV_EN` undefined → DIV gives `y = 0`, `stall` never asserts, HI/LO unchanged.
